// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package rr_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   localparam int N_REQ = 4;

   typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/mux_4to1.sv
// Single-bit 4:1 multiplexer used to steer one data bit per instance.
module mux_4to1 (
   input  logic [3:0] d,
   input  logic [1:0] s,
   output logic       y
);

   assign y = d[s];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one valid/ready output between four requesters.
// A grant is held for up to MAX_BURST accepted beats or until the owner drops
// its request; the next owner is chosen on the same edge, so there is no idle
// bubble while other requests are pending.
module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] data_in,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [N_REQ-1:0]        grant,
   output logic [1:0]              sel,
   output logic                    busy
);

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   req_idx_t         sel_q, sel_d;
   req_idx_t         ptr_q, ptr_d;
   logic [3:0]       cnt_q, cnt_d;
   req_idx_t         winner;
   logic             beat;
   logic             release_now;

   // First asserted request found when scanning upward from start, wrapping
   // modulo four; the start position has the highest priority.
   function automatic req_idx_t rr_pick(input logic [N_REQ-1:0] r, input req_idx_t start);
      req_idx_t idx;
      rr_pick = start;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = start + req_idx_t'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   assign busy        = (state_q == GRANT);
   assign out_valid   = busy && req[sel_q];
   assign beat        = out_valid && out_ready;
   assign release_now = busy && (!req[sel_q] || (beat && (cnt_q == LAST_BEAT)));
   assign grant       = grant_q;
   assign sel         = sel_q;

   // One mux per data bit, all sharing the registered select.
   for (genvar b = 0; b < DATA_W; b++) begin : g_mux
      mux_4to1 u_mux (
         .d ({data_in[3*DATA_W+b], data_in[2*DATA_W+b], data_in[DATA_W+b], data_in[b]}),
         .s (sel_q),
         .y (out_data[b])
      );
   end

   // Next-state logic: arbitrate from IDLE, count beats, and on release
   // rotate the pointer past the owner and re-arbitrate in the same cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      winner  = '0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               winner  = rr_pick(req, ptr_q);
               state_d = GRANT;
               grant_d = 4'b0001 << winner;
               sel_d   = winner;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_d = sel_q + 2'd1;
               cnt_d = '0;
               if (|req) begin
                  winner  = rr_pick(req, sel_q + 2'd1);
                  grant_d = 4'b0001 << winner;
                  sel_d   = winner;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (beat) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; reset drops any grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_rr_mux_arbiter;

   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic                clk;
   logic                rst_n;
   logic [3:0]          req;
   logic [4*DATA_W-1:0] data_in;
   logic                out_ready;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic [3:0]          grant;
   logic [1:0]          sel;
   logic                busy;

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 0;

   // Behavioural model: owner is -1 when idle
   int mOwner = -1;
   int mPtr   = 0;
   int mBeats = 0;

   rr_mux_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .grant     (grant),
      .sel       (sel),
      .busy      (busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   // Model advances on each clock edge and clears asynchronously on reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mOwner = -1;
         mPtr   = 0;
         mBeats = 0;
      end else if (mOwner < 0) begin
         if (req != 0) begin
            mOwner = pick(req, mPtr);
            mBeats = 0;
         end
      end else begin
         bit accepted;
         accepted = req[mOwner] && out_ready;
         if (!req[mOwner] || (accepted && (mBeats + 1 == MAX_BURST))) begin
            mPtr   = (mOwner + 1) % 4;
            mOwner = (req != 0) ? pick(req, mPtr) : -1;
            mBeats = 0;
         end else if (accepted) begin
            mBeats = mBeats + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare process: DUT outputs against the model on every falling edge
   always @(negedge clk) begin
      if (checkEn) begin
         logic [3:0] expGrant;
         expGrant = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
         checkOutput("grant", 32'(grant), 32'(expGrant));
         checkOutput("busy", 32'(busy), 32'(mOwner >= 0));
         checkOutput("out_valid", 32'(out_valid), 32'((mOwner >= 0) && req[(mOwner < 0) ? 0 : mOwner]));
         if (mOwner >= 0) begin
            checkOutput("sel", 32'(sel), 32'(mOwner));
            checkOutput("out_data", 32'(out_data), 32'(data_in[mOwner*DATA_W +: DATA_W]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [4*DATA_W-1:0] d, input logic rdy);
      req       = r;
      data_in   = d;
      out_ready = rdy;
   endtask

   task automatic doReset();
      rst_n = 0;
      applyStimulus(4'b0000, '0, 1'b0);
      tick();
      tick();
      rst_n = 1;
   endtask

   int selSeq[$];
   int expSeq[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

   initial begin
      rst_n = 1;
      applyStimulus(4'b0000, '0, 1'b0);
      #2;
      doReset();
      checkEn = 1;
      checkOutput("reset_grant", 32'(grant), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);

      // Single requester on slice 2
      applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
      tick();
      checkOutput("single_grant", 32'(grant), 32'h4);
      checkOutput("single_sel", 32'(sel), 32'h2);
      checkOutput("single_data", 32'(out_data), 32'hA5);
      repeat (4) tick();
      checkOutput("single_regrant", 32'(grant), 32'h4);

      // All requesters: strict rotation with full bursts
      doReset();
      applyStimulus(4'b1111, 32'h4433_2211, 1'b1);
      for (int i = 0; i < 17; i++) begin
         tick();
         selSeq.push_back(int'(sel));
         checkOutput("rotate_valid", 32'(out_valid), 32'h1);
      end
      for (int i = 0; i < 17; i++) checkOutput("rotate_sel", 32'(selSeq[i]), 32'(expSeq[i]));

      // Backpressure on requester 1
      doReset();
      applyStimulus(4'b0010, 32'h0000_5A00, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("stall_grant", 32'(grant), 32'h2);
         checkOutput("stall_valid", 32'(out_valid), 32'h1);
      end
      applyStimulus(4'b0011, 32'h0000_5A3C, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("resume_grant", 32'(grant), 32'h2);
      end
      tick();
      checkOutput("resume_handoff", 32'(grant), 32'h1);

      // Early drop by requester 3, pointer wraps to 0
      doReset();
      applyStimulus(4'b1000, 32'h7700_0000, 1'b1);
      tick();
      checkOutput("drop_grant3", 32'(grant), 32'h8);
      tick();
      tick();
      applyStimulus(4'b0001, 32'h0000_0066, 1'b1);
      tick();
      checkOutput("drop_wrap", 32'(grant), 32'h1);
      checkOutput("drop_data", 32'(out_data), 32'h66);

      // No preemption of requester 0 by requester 1
      doReset();
      applyStimulus(4'b0001, 32'h0000_0011, 1'b1);
      tick();
      tick();
      applyStimulus(4'b0011, 32'h0000_2211, 1'b1);
      tick();
      checkOutput("nopre_hold1", 32'(grant), 32'h1);
      tick();
      checkOutput("nopre_hold2", 32'(grant), 32'h1);
      tick();
      checkOutput("nopre_switch", 32'(grant), 32'h2);

      // Reset mid-burst takes effect without a clock edge
      doReset();
      applyStimulus(4'b0010, 32'h0000_9900, 1'b1);
      tick();
      checkOutput("midrst_pre", 32'(grant), 32'h2);
      #2;
      rst_n = 0;
      #1;
      checkOutput("midrst_grant", 32'(grant), 32'h0);
      checkOutput("midrst_valid", 32'(out_valid), 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      applyStimulus(4'b0000, '0, 1'b1);
      tick();
      rst_n = 1;
      tick();
      tick();
      checkOutput("midrst_idle", 32'(grant), 32'h0);
      checkOutput("midrst_idle_busy", 32'(busy), 32'h0);

      // Randomized traffic against the model
      doReset();
      for (int i = 0; i < 600; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 32'($urandom), 1'($urandom_range(0, 3) != 0));
         tick();
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 0;
            #2;
            rst_n = 1;
         end
      end

      checkEn = 0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
